// File: rtl/chunked_adder.sv
// chunked_adder
// Multi-cycle add/subtract unit. A WIDTH-bit operation is processed CHUNK bits
// per cycle, least significant chunk first, with the carry held in a register
// between cycles. One operation in flight; valid/ready handshake on both sides.
//
// Ports
//   clk         clock, all state on rising edge
//   rstn_i      synchronous active-low reset
//   valid_i     operands valid
//   ready_o     unit can accept operands (IDLE only)
//   a_i, b_i    operands (WIDTH bits)
//   carry_i     carry-in (add) / borrow-in (sub)
//   sub_i       0: a+b+carry_i, 1: a-b-carry_i
//   valid_o     result valid (DONE only)
//   ready_i     consumer accepts result
//   r_o         result, held until the next DONE
//   carry_o     raw carry out of bit WIDTH-1 (sub: 1 = no borrow)
//   overflow_o  signed overflow
//   zero_o      result is zero
//
// state | meaning
// IDLE  | waiting for operands, ready_o=1
// RUN   | one chunk per cycle, cnt = chunk being computed
// DONE  | result presented, waiting for ready_i
module chunked_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rstn_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             carry_i,
   input  logic             sub_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] r_o,
   output logic             carry_o,
   output logic             overflow_o,
   output logic             zero_o
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   a_reg, b_reg, acc, r_reg;
   logic               carry_reg, carry_out_reg, ovf_reg, zero_reg;
   logic [CHUNK:0]     chunk_sum;
   logic [WIDTH+CHUNK-1:0] acc_cat;
   logic [WIDTH-1:0]   acc_nxt;
   logic               accept, last;

   // Operands are shifted right each step, so the active chunk is always
   // the bottom CHUNK bits; the result is shifted in from the top.
   always_comb begin
      chunk_sum = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, carry_reg};
      acc_cat   = {chunk_sum[CHUNK-1:0], acc};
      acc_nxt   = acc_cat[WIDTH+CHUNK-1:CHUNK];
   end

   always_comb begin
      state_nxt = state;
      ready_o   = 1'b0;
      valid_o   = 1'b0;
      accept    = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            ready_o = 1'b1;
            accept  = valid_i;
            if (valid_i) state_nxt = RUN;
         end
         RUN: begin
            last = (cnt == LAST);
            if (last) state_nxt = DONE;
         end
         DONE: begin
            valid_o = 1'b1;
            if (ready_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn_i) begin
         state         <= IDLE;
         cnt           <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         acc           <= '0;
         r_reg         <= '0;
         carry_reg     <= 1'b0;
         carry_out_reg <= 1'b0;
         ovf_reg       <= 1'b0;
         zero_reg      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_reg     <= a_i;
            b_reg     <= sub_i ? ~b_i : b_i;
            carry_reg <= sub_i ? ~carry_i : carry_i;
            acc       <= '0;
            cnt       <= '0;
         end
         if (state == RUN) begin
            a_reg     <= a_reg >> CHUNK;
            b_reg     <= b_reg >> CHUNK;
            acc       <= acc_nxt;
            carry_reg <= chunk_sum[CHUNK];
            cnt       <= last ? '0 : cnt + CW'(1);
            if (last) begin
               r_reg         <= acc_nxt;
               carry_out_reg <= chunk_sum[CHUNK];
               // carry into the MSB recovered from the MSB sum bit: a^b^s
               ovf_reg       <= a_reg[CHUNK-1] ^ b_reg[CHUNK-1]
                              ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];
               zero_reg      <= (acc_nxt == '0);
            end
         end
      end
   end

   assign r_o        = r_reg;
   assign carry_o    = carry_out_reg;
   assign overflow_o = ovf_reg;
   assign zero_o     = zero_reg;

endmodule
